// File: rtl/gpu_pkg.sv
// Shared frame-buffer geometry and fill-writer state encoding.
// No logic; constants and types only.
// Used by fill_span_writer and span_addr_gen.
package gpu_pkg;

  localparam int H_RES   = 640;
  localparam int V_RES   = 480;
  localparam int COORD_W = 10;
  localparam int COLOR_W = 8;
  localparam int ADDR_W  = 19;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CALC  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    HOLD  = 3'd4
  } fill_wr_state_t;

endpackage

// File: rtl/span_addr_gen.sv
// Span address generator: latches span coordinates, forms row base, steps x/address.
// Latency: base address registered one cycle after calc; advance updates next cycle.
// Backpressure: address only moves on advance, so it holds while writes are stalled.
module span_addr_gen
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic               calc,
  input  logic               advance,
  input  logic [COORD_W-1:0] x_left,
  input  logic [COORD_W-1:0] x_right,
  input  logic [COORD_W-1:0] y_row,
  output logic [ADDR_W-1:0]  addr,
  output logic [COORD_W-1:0] row,
  output logic               last,
  output logic               empty
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);

  logic [COORD_W-1:0] x_cur;
  logic [COORD_W-1:0] x_right_q;
  logic [COORD_W-1:0] y_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [COORD_W-1:0] x_end;
  logic [ADDR_W-1:0]  base;

  // Clip the span end to the last column so the address never runs into the next row.
  always_comb begin
    x_end = (x_right_q > X_MAX) ? X_MAX : x_right_q;
    base  = ADDR_W'(y_q) * ADDR_W'(H_RES) + ADDR_W'(x_cur);
    empty = (x_cur > x_end) || (x_cur >= X_LIM) || (y_q >= Y_LIM);
    last  = (x_cur == x_end);
  end

  // Coordinate latch at accept, base load in CALC, x/address step per accepted write.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      x_cur     <= '0;
      x_right_q <= '0;
      y_q       <= '0;
      addr_q    <= '0;
    end else if (load) begin
      x_cur     <= x_left;
      x_right_q <= x_right;
      y_q       <= y_row;
    end else if (calc) begin
      addr_q <= base;
    end else if (advance) begin
      x_cur  <= x_cur + 1'b1;
      addr_q <= addr_q + 1'b1;
    end
  end

  assign addr = addr_q;
  assign row  = y_q;

endmodule

// File: rtl/fill_span_writer.sv
// Writes fill_color to every pixel of one row span, then pulses fill_done.
// Latency: first write request 2 cycles after fill_start; one pixel/cycle with steady ack.
// Backpressure: request, address and data hold until mem_wr_ack; HOLD waits for fill_start low.
module fill_span_writer
  import gpu_pkg::*;
(
  input  logic               clk,
  input  logic               n_rst,
  input  logic               fill_start,
  input  logic [COORD_W-1:0] x_left,
  input  logic [COORD_W-1:0] x_right,
  input  logic [COORD_W-1:0] y_row,
  input  logic [COORD_W-1:0] y_last,
  input  logic [COLOR_W-1:0] fill_color,
  output logic               mem_wr_req,
  output logic [ADDR_W-1:0]  mem_wr_addr,
  output logic [COLOR_W-1:0] mem_wr_data,
  input  logic               mem_wr_ack,
  output logic               fill_done,
  output logic               fill_complete,
  output logic               busy
);

  fill_wr_state_t     state;
  logic [COORD_W-1:0] y_last_q;
  logic [COORD_W-1:0] row;
  logic               last;
  logic               empty;
  logic               load;
  logic               calc;
  logic               advance;

  // Strobes into the address generator, decoded from the current state.
  always_comb begin
    load    = (state == IDLE) && fill_start;
    calc    = (state == CALC);
    advance = (state == WRITE) && mem_wr_ack && !last;
  end

  span_addr_gen u_addr_gen (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (load),
    .calc    (calc),
    .advance (advance),
    .x_left  (x_left),
    .x_right (x_right),
    .y_row   (y_row),
    .addr    (mem_wr_addr),
    .row     (row),
    .last    (last),
    .empty   (empty)
  );

  // Span FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state         <= IDLE;
      mem_wr_req    <= 1'b0;
      mem_wr_data   <= '0;
      fill_done     <= 1'b0;
      fill_complete <= 1'b0;
      busy          <= 1'b0;
      y_last_q      <= '0;
    end else begin
      fill_done <= 1'b0;
      case (state)
        IDLE: begin
          if (fill_start) begin
            mem_wr_data   <= fill_color;
            y_last_q      <= y_last;
            fill_complete <= 1'b0;
            busy          <= 1'b1;
            state         <= CALC;
          end
        end
        CALC: begin
          if (empty) begin
            fill_done     <= 1'b1;
            fill_complete <= (row == y_last_q);
            state         <= DONE;
          end else begin
            mem_wr_req <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: begin
          if (mem_wr_ack && last) begin
            mem_wr_req    <= 1'b0;
            fill_done     <= 1'b1;
            fill_complete <= (row == y_last_q);
            state         <= DONE;
          end
        end
        DONE: begin
          state <= HOLD;
        end
        HOLD: begin
          if (!fill_start) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          mem_wr_req <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fill_span_writer.sv
module tb_fill_span_writer;
  import gpu_pkg::*;

  logic               clk = 1'b0;
  logic               n_rst = 1'b1;
  logic               fill_start = 1'b0;
  logic [COORD_W-1:0] x_left = '0;
  logic [COORD_W-1:0] x_right = '0;
  logic [COORD_W-1:0] y_row = '0;
  logic [COORD_W-1:0] y_last = '0;
  logic [COLOR_W-1:0] fill_color = '0;
  logic               mem_wr_req;
  logic [ADDR_W-1:0]  mem_wr_addr;
  logic [COLOR_W-1:0] mem_wr_data;
  logic               mem_wr_ack = 1'b0;
  logic               fill_done;
  logic               fill_complete;
  logic               busy;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] data;
  } wr_t;

  wr_t sb[$];

  fill_span_writer dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .fill_start    (fill_start),
    .x_left        (x_left),
    .x_right       (x_right),
    .y_row         (y_row),
    .y_last        (y_last),
    .fill_color    (fill_color),
    .mem_wr_req    (mem_wr_req),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ack    (mem_wr_ack),
    .fill_done     (fill_done),
    .fill_complete (fill_complete),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Expected writes for one span, computed from frame geometry.
  task automatic push_expected(input int xl, input int xr, input int y, input logic [COLOR_W-1:0] col);
    int xe;
    wr_t w;
    xe = (xr > H_RES - 1) ? H_RES - 1 : xr;
    if (xl <= xe && xl < H_RES && y < V_RES) begin
      for (int x = xl; x <= xe; x++) begin
        w.addr = ADDR_W'(y * H_RES + x);
        w.data = col;
        sb.push_back(w);
      end
    end
  endtask

  // Drives one span; cycle 0 is the cycle fill_start is presented. Writes are scoreboarded.
  task automatic run_span(input int xl, input int xr, input int y, input int yl,
                          input logic [COLOR_W-1:0] col, input int period, input int extra_hold,
                          output int n_wr, output int first_req, output int last_wr,
                          output int done_cyc, output int n_done, output int stab_err,
                          output int idle_cyc, output logic cmp_at1, output logic cmp_done);
    int cyc;
    int drop_at;
    bit seen_done;
    logic prev_stall;
    logic [ADDR_W-1:0] prev_addr;
    logic [COLOR_W-1:0] prev_data;
    wr_t exp_w;
    push_expected(xl, xr, y, col);
    n_wr = 0; first_req = -1; last_wr = -1; done_cyc = -1; n_done = 0;
    stab_err = 0; idle_cyc = -1; cmp_at1 = 1'bx; cmp_done = 1'bx;
    x_left = COORD_W'(xl); x_right = COORD_W'(xr); y_row = COORD_W'(y); y_last = COORD_W'(yl);
    fill_color = col;
    fill_start = 1'b1;
    cyc = 0; drop_at = 0; seen_done = 0; prev_stall = 1'b0;
    prev_addr = '0; prev_data = '0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 300) begin
        n_vec++; n_err++;
        $display("FAIL span_timeout: busy=%0b after %0d cycles, required idle", busy, cyc);
        break;
      end
      if (cyc == 1) cmp_at1 = fill_complete;
      if (prev_stall && (!mem_wr_req || mem_wr_addr !== prev_addr || mem_wr_data !== prev_data))
        stab_err++;
      if (mem_wr_req && first_req < 0) first_req = cyc;
      if (fill_done) begin
        n_done++;
        if (!seen_done) begin
          done_cyc = cyc;
          cmp_done = fill_complete;
          drop_at  = cyc + extra_hold;
        end
        seen_done = 1;
      end
      if (seen_done && cyc >= drop_at) fill_start = 1'b0;
      if (seen_done && !busy) begin
        idle_cyc = cyc;
        break;
      end
      mem_wr_ack = (period <= 1) || (cyc % period == 0);
      if (mem_wr_req && mem_wr_ack) begin
        n_wr++;
        last_wr = cyc;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: addr=%0d data=%0h, required no write", mem_wr_addr, mem_wr_data);
        end else begin
          exp_w = sb.pop_front();
          if (mem_wr_addr !== exp_w.addr || mem_wr_data !== exp_w.data) begin
            n_err++;
            $display("FAIL write_data: addr=%0d data=%0h, required addr=%0d data=%0h",
                     mem_wr_addr, mem_wr_data, exp_w.addr, exp_w.data);
          end
        end
      end
      prev_stall = mem_wr_req && !mem_wr_ack;
      prev_addr  = mem_wr_addr;
      prev_data  = mem_wr_data;
    end
    mem_wr_ack = 1'b0;
    fill_start = 1'b0;
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL missing_writes: %0d outstanding, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_state();
    n_vec++;
    if (mem_wr_req !== 1'b0 || fill_done !== 1'b0 || fill_complete !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: req=%b done=%b cmpl=%b busy=%b, required 0000",
               mem_wr_req, fill_done, fill_complete, busy);
    end
    n_vec++;
    if (mem_wr_addr !== '0 || mem_wr_data !== '0) begin
      n_err++;
      $display("FAIL reset_bus: addr=%0d data=%0h, required 0/0", mem_wr_addr, mem_wr_data);
    end
    n_vec++;
    if (dut.state !== IDLE) begin
      n_err++;
      $display("FAIL reset_state: state=%0d, required IDLE", dut.state);
    end
  endtask

  task automatic test_basic();
    int n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc;
    logic c1, cd;
    run_span(3, 6, 2, 9, 8'hA5, 1, 0, n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc, c1, cd);
    n_vec++;
    if (n_wr !== 4) begin n_err++; $display("FAIL basic_count: %0d writes, required 4", n_wr); end
    n_vec++;
    if (first_req !== 2) begin n_err++; $display("FAIL basic_first_req: cycle %0d, required 2", first_req); end
    n_vec++;
    if (last_wr !== 5) begin n_err++; $display("FAIL basic_back_to_back: last write cycle %0d, required 5", last_wr); end
    n_vec++;
    if (n_done !== 1 || done_cyc !== 6) begin
      n_err++; $display("FAIL basic_done: %0d pulses at cycle %0d, required 1 at 6", n_done, done_cyc);
    end
    n_vec++;
    if (cd !== 1'b0) begin n_err++; $display("FAIL basic_complete: %b, required 0", cd); end
    n_vec++;
    if (idle_cyc !== 8) begin n_err++; $display("FAIL basic_idle: cycle %0d, required 8", idle_cyc); end
  endtask

  task automatic test_stall();
    int n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc;
    logic c1, cd;
    run_span(3, 6, 2, 9, 8'h3C, 3, 0, n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc, c1, cd);
    n_vec++;
    if (n_wr !== 4) begin n_err++; $display("FAIL stall_count: %0d writes, required 4", n_wr); end
    n_vec++;
    if (stab_err !== 0) begin n_err++; $display("FAIL stall_hold: %0d unstable cycles, required 0", stab_err); end
    n_vec++;
    if (n_done !== 1 || done_cyc !== 13) begin
      n_err++; $display("FAIL stall_done: %0d pulses at cycle %0d, required 1 at 13", n_done, done_cyc);
    end
  endtask

  task automatic test_empty_last_row();
    int n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc;
    logic c1, cd;
    run_span(10, 4, 479, 479, 8'h11, 1, 0, n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc, c1, cd);
    n_vec++;
    if (n_wr !== 0 || first_req !== -1) begin
      n_err++; $display("FAIL empty_writes: %0d writes, first req %0d, required 0/-1", n_wr, first_req);
    end
    n_vec++;
    if (n_done !== 1 || done_cyc !== 2) begin
      n_err++; $display("FAIL empty_done: %0d pulses at cycle %0d, required 1 at 2", n_done, done_cyc);
    end
    n_vec++;
    if (cd !== 1'b1) begin n_err++; $display("FAIL empty_complete: %b, required 1", cd); end
    repeat (3) begin @(posedge clk); #1; end
    n_vec++;
    if (fill_complete !== 1'b1) begin n_err++; $display("FAIL complete_held: %b, required 1", fill_complete); end
    run_span(0, 1, 5, 9, 8'h22, 1, 0, n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc, c1, cd);
    n_vec++;
    if (c1 !== 1'b0 || cd !== 1'b0) begin
      n_err++; $display("FAIL complete_clear: at accept %b at done %b, required 0/0", c1, cd);
    end
  endtask

  task automatic test_clip();
    int n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc;
    logic c1, cd;
    run_span(630, 700, 0, 3, 8'hF0, 1, 0, n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc, c1, cd);
    n_vec++;
    if (n_wr !== 10) begin n_err++; $display("FAIL clip_count: %0d writes, required 10", n_wr); end
    n_vec++;
    if (n_done !== 1 || done_cyc !== 12) begin
      n_err++; $display("FAIL clip_done: %0d pulses at cycle %0d, required 1 at 12", n_done, done_cyc);
    end
  endtask

  task automatic test_hold();
    int n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc;
    logic c1, cd;
    run_span(3, 6, 9, 9, 8'h5A, 1, 3, n_wr, first_req, last_wr, done_cyc, n_done, stab_err, idle_cyc, c1, cd);
    n_vec++;
    if (n_wr !== 4 || n_done !== 1) begin
      n_err++; $display("FAIL hold_single_span: %0d writes %0d pulses, required 4/1", n_wr, n_done);
    end
    n_vec++;
    if (idle_cyc !== done_cyc + 4) begin
      n_err++; $display("FAIL hold_release: idle at %0d, required %0d", idle_cyc, done_cyc + 4);
    end
    n_vec++;
    if (cd !== 1'b1) begin n_err++; $display("FAIL hold_complete: %b, required 1", cd); end
  endtask

  task automatic test_reset_mid_write();
    x_left = 10'd3; x_right = 10'd10; y_row = 10'd1; y_last = 10'd9; fill_color = 8'h77;
    fill_start = 1'b1;
    mem_wr_ack = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    n_vec++;
    if (mem_wr_req !== 1'b1 || mem_wr_addr !== 19'd645) begin
      n_err++; $display("FAIL rst_pre: req=%b addr=%0d, required 1/645", mem_wr_req, mem_wr_addr);
    end
    n_rst = 1'b1;
    fill_start = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (mem_wr_req !== 1'b0 || fill_done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rst_drop: req=%b done=%b busy=%b, required 000", mem_wr_req, fill_done, busy);
    end
    @(posedge clk); #1;
    n_rst = 1'b0;
    mem_wr_ack = 1'b0;
    n_vec++;
    if (dut.state !== IDLE || mem_wr_addr !== '0) begin
      n_err++; $display("FAIL rst_idle: state=%0d addr=%0d, required IDLE/0", dut.state, mem_wr_addr);
    end
    test_basic();
  endtask

  initial begin
    n_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    test_reset_state();
    n_rst = 1'b0;
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_empty_last_row();
    test_clip();
    test_hold();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
